// File: rtl/tdc_phase_calibrator.sv
// Phase-calibration controller for the TDC delay line: steps the MMCM dynamic
// phase shifter until the measured bin count falls inside a window around q_nom.
module tdc_phase_calibrator #(
    parameter int Q_WIDTH        = 8,
    parameter int INIT_STEPS     = 1300,
    parameter int SETTLE_CYCLES  = 16,
    parameter int MAX_STEPS      = 4096,
    parameter int PSDONE_TIMEOUT = 1024,
    parameter int STEP_W         = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [Q_WIDTH-1:0] q_nom,
    input  logic [Q_WIDTH-1:0] q_tol,
    input  logic [Q_WIDTH-1:0] q_meas,
    input  logic               q_valid,
    input  logic               psdone,
    output logic               psen,
    output logic               psincdec,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [STEP_W-1:0]  step_count,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        INIT_PS    = 4'd1,
        INIT_WAIT  = 4'd2,
        SETTLE     = 4'd3,
        MEASURE    = 4'd4,
        ADJ_PS     = 4'd5,
        ADJ_WAIT   = 4'd6,
        DONE       = 4'd7,
        FAIL       = 4'd8,
        ABORT_WAIT = 4'd9
    } state_t;

    localparam int INIT_W   = (INIT_STEPS < 1) ? 1 : $clog2(INIT_STEPS + 1);
    localparam int SETTLE_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W     = (PSDONE_TIMEOUT < 1) ? 1 : $clog2(PSDONE_TIMEOUT + 1);
    localparam logic [STEP_W-1:0] MAX_STEPS_C = STEP_W'(MAX_STEPS);

    // Window bounds are one bit wider than the operands so borrow/carry is visible.
    function automatic logic [Q_WIDTH:0] win_lo(input logic [Q_WIDTH-1:0] nom,
                                                input logic [Q_WIDTH-1:0] tol);
        logic [Q_WIDTH:0] d;
        d = {1'b0, nom} - {1'b0, tol};
        return d[Q_WIDTH] ? '0 : d;
    endfunction

    function automatic logic [Q_WIDTH:0] win_hi(input logic [Q_WIDTH-1:0] nom,
                                                input logic [Q_WIDTH-1:0] tol);
        logic [Q_WIDTH:0] s;
        s = {1'b0, nom} + {1'b0, tol};
        return s[Q_WIDTH] ? {1'b0, {Q_WIDTH{1'b1}}} : s;
    endfunction

    state_t              st;
    logic [INIT_W-1:0]   init_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [Q_WIDTH-1:0]  nom_r;
    logic [Q_WIDTH-1:0]  tol_r;
    logic [Q_WIDTH:0]    lo;
    logic [Q_WIDTH:0]    hi;
    logic [Q_WIDTH:0]    meas_x;
    logic                to_hit;

    assign lo     = win_lo(nom_r, tol_r);
    assign hi     = win_hi(nom_r, tol_r);
    assign meas_x = {1'b0, q_meas};
    assign to_hit = (int'(to_cnt) + 1 >= PSDONE_TIMEOUT);

    assign ready = (st == IDLE);
    assign busy  = ~ready;
    assign state = st;

    always_ff @(posedge clk) begin
        if (st == IDLE && start) begin
            nom_r <= q_nom;
            tol_r <= q_tol;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st         <= IDLE;
            psen       <= 1'b0;
            psincdec   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            step_count <= '0;
            init_cnt   <= '0;
            settle_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            psen <= 1'b0;
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        error      <= 1'b0;
                        step_count <= '0;
                        init_cnt   <= '0;
                        settle_cnt <= '0;
                        st         <= (INIT_STEPS == 0) ? SETTLE : INIT_PS;
                    end
                end
                INIT_PS: begin
                    if (abort) begin
                        st <= IDLE;
                    end else begin
                        psen     <= 1'b1;
                        psincdec <= 1'b1;
                        to_cnt   <= '0;
                        st       <= INIT_WAIT;
                    end
                end
                INIT_WAIT: begin
                    if (psdone) begin
                        if (abort) begin
                            st <= IDLE;
                        end else begin
                            init_cnt <= init_cnt + 1'b1;
                            if (int'(init_cnt) + 1 >= INIT_STEPS) begin
                                settle_cnt <= '0;
                                st         <= SETTLE;
                            end else begin
                                st <= INIT_PS;
                            end
                        end
                    end else if (abort) begin
                        to_cnt <= to_cnt + 1'b1;
                        st     <= ABORT_WAIT;
                    end else if (to_hit) begin
                        st <= FAIL;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        st <= IDLE;
                    end else if (int'(settle_cnt) + 1 >= SETTLE_CYCLES) begin
                        st <= MEASURE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (abort) begin
                        st <= IDLE;
                    end else if (q_valid) begin
                        if (meas_x >= lo && meas_x <= hi) begin
                            st <= DONE;
                        end else begin
                            psincdec <= (meas_x > hi) ? 1'b0 : 1'b1;
                            st       <= (step_count == MAX_STEPS_C) ? FAIL : ADJ_PS;
                        end
                    end
                end
                ADJ_PS: begin
                    if (abort) begin
                        st <= IDLE;
                    end else begin
                        psen   <= 1'b1;
                        to_cnt <= '0;
                        if (step_count != '1) step_count <= step_count + 1'b1;
                        st     <= ADJ_WAIT;
                    end
                end
                ADJ_WAIT: begin
                    if (psdone) begin
                        settle_cnt <= '0;
                        st         <= abort ? IDLE : SETTLE;
                    end else if (abort) begin
                        to_cnt <= to_cnt + 1'b1;
                        st     <= ABORT_WAIT;
                    end else if (to_hit) begin
                        st <= FAIL;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    st   <= IDLE;
                end
                FAIL: begin
                    error <= 1'b1;
                    done  <= 1'b1;
                    st    <= IDLE;
                end
                // The MMCM forbids a new request until the outstanding step is acknowledged.
                ABORT_WAIT: begin
                    if (psdone || to_hit) begin
                        st <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_phase_calibrator.sv
// Scoreboard bench for tdc_phase_calibrator: directed runs push expected psen
// directions and done results; a monitor pops and compares on each DUT pulse.
module tb_tdc_phase_calibrator;

    localparam int QW = 8;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [QW-1:0] q_nom = '0;
    logic [QW-1:0] q_tol = '0;
    logic [QW-1:0] q_meas = '0;
    logic          q_valid = 1'b0;
    logic          psdone = 1'b0;
    logic          psen;
    logic          psincdec;
    logic          ready;
    logic          busy;
    logic          done;
    logic          error;
    logic [SW-1:0] step_count;
    logic [3:0]    state;

    tdc_phase_calibrator #(
        .Q_WIDTH(QW), .INIT_STEPS(4), .SETTLE_CYCLES(2), .MAX_STEPS(8),
        .PSDONE_TIMEOUT(20), .STEP_W(SW)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .q_nom(q_nom), .q_tol(q_tol), .q_meas(q_meas), .q_valid(q_valid),
        .psdone(psdone), .psen(psen), .psincdec(psincdec), .ready(ready),
        .busy(busy), .done(done), .error(error), .step_count(step_count),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          err;
        logic [SW-1:0] steps;
    } done_t;

    logic  exp_dir[$];
    done_t exp_done[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    n_done = 0;
    logic  suppress = 1'b0;
    logic  dec_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // MMCM model: psdone 3 cycles after each psen; optional q_meas decrement on dec steps.
    initial begin
        int dly;
        dly = 0;
        forever begin
            @(negedge clk);
            psdone = 1'b0;
            if (dly > 0) begin
                dly--;
                if (dly == 0 && !suppress) begin
                    psdone = 1'b1;
                    if (dec_mode && !psincdec) q_meas = q_meas - 1'b1;
                end
            end
            if (psen) dly = 3;
        end
    end

    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c++;
            q_valid = (c % 5 == 0);
        end
    end

    // Monitor: every psen or done pulse is matched against the scoreboard.
    initial begin
        logic  d;
        done_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (psen) begin
                    if (exp_dir.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL psen_unexpected got=1 exp=0 dir=%0d", psincdec);
                    end else begin
                        d = exp_dir.pop_front();
                        check("psen_dir", 32'(psincdec), 32'(d));
                    end
                end
                if (done) begin
                    n_done++;
                    if (exp_done.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL done_unexpected got=1 exp=0 err=%0d", error);
                    end else begin
                        e = exp_done.pop_front();
                        check("done_error", 32'(error), 32'(e.err));
                        check("done_steps", 32'(step_count), 32'(e.steps));
                    end
                end
            end
        end
    end

    task automatic push_dirs(input logic dir, input int n);
        for (int i = 0; i < n; i++) exp_dir.push_back(dir);
    endtask

    task automatic push_done(input logic err, input int steps);
        done_t e;
        e.err   = err;
        e.steps = SW'(steps);
        exp_done.push_back(e);
    endtask

    task automatic run_cal(input logic [QW-1:0] nom, input logic [QW-1:0] tol);
        @(negedge clk);
        q_nom = nom;
        q_tol = tol;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int k;
        d0 = n_done;
        k = 0;
        while (n_done == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_done == d0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_no_done got=none exp=pulse", name);
        end
    endtask

    task automatic wait_state(input string name, input logic [3:0] s, input int budget);
        int k;
        k = 0;
        while (state != s && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_reach"}, 32'(state), 32'(s));
    endtask

    task automatic end_test(input string name);
        repeat (10) @(negedge clk);
        check({name, "_psen_left"}, 32'(exp_dir.size()), 32'd0);
        check({name, "_done_left"}, 32'(exp_done.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_step", 32'(step_count), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Init sweep then immediate lock.
        q_meas = 8'd80;
        push_dirs(1'b1, 4);
        push_done(1'b0, 0);
        run_cal(8'd80, 8'd0);
        check("start_busy", 32'(busy), 32'd1);
        wait_done("lock", 500);
        end_test("lock");

        // Search down: 85 -> 82 needs 3 decrement steps.
        q_meas   = 8'd85;
        dec_mode = 1'b1;
        push_dirs(1'b1, 4);
        push_dirs(1'b0, 3);
        push_done(1'b0, 3);
        run_cal(8'd80, 8'd2);
        wait_done("search", 1000);
        end_test("search");
        check("search_qmeas", 32'(q_meas), 32'd82);
        dec_mode = 1'b0;

        // lo saturates to 0, so q_meas=0 locks without searching.
        q_meas = 8'd0;
        push_dirs(1'b1, 4);
        push_done(1'b0, 0);
        run_cal(8'd1, 8'd5);
        wait_done("sat", 500);
        end_test("sat");

        // Step limit: 8 increments then failure.
        q_meas = 8'd10;
        push_dirs(1'b1, 4 + 8);
        push_done(1'b1, 8);
        run_cal(8'd80, 8'd0);
        wait_done("limit", 2000);
        end_test("limit");
        check("limit_err_sticky", 32'(error), 32'd1);

        // Timeout: no psdone, single psen, then failure.
        suppress = 1'b1;
        push_dirs(1'b1, 1);
        push_done(1'b1, 0);
        run_cal(8'd80, 8'd0);
        check("start_clears_err", 32'(error), 32'd0);
        wait_done("timeout", 200);
        end_test("timeout");
        suppress = 1'b0;

        // Abort in ADJ_WAIT waits for psdone, no done pulse.
        q_meas = 8'd10;
        push_dirs(1'b1, 5);
        run_cal(8'd80, 8'd0);
        wait_state("abort_adj", 4'd6, 500);
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wait_state", 32'(state), 32'd9);
        @(negedge clk);
        abort = 1'b0;
        check("abort_hold", 32'(state), 32'd9);
        wait_state("abort_idle", 4'd0, 50);
        check("abort_steps", 32'(step_count), 32'd1);
        end_test("abort");

        // Asynchronous reset mid-sweep.
        push_dirs(1'b1, 1);
        run_cal(8'd80, 8'd0);
        wait_state("rst_sweep", 4'd2, 50);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_psincdec", 32'(psincdec), 32'd0);
        check("midrst_psen", 32'(psen), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        end_test("midrst");
        check("post_rst_state", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
